// File: rtl/mood_state_engine.sv
// Saturating emotion channels with decay toward per-channel baselines, quadrant
// indicators, and a four-state sleep FSM driven by energy (ch0) and stress (ch1).
module mood_state_engine #(
   parameter int                    NUM_CH       = 3,
   parameter int                    WIDTH        = 7,
   parameter int                    STEP_W       = 3,
   parameter logic [NUM_CH*WIDTH-1:0] BASELINE   = {7'd64, 7'd0, 7'd96},
   parameter int                    DECAY_PERIOD = 16,
   parameter int                    SLEEP_DELAY  = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      tick,
   input  logic [NUM_CH-1:0]         inc,
   input  logic [NUM_CH-1:0]         dec,
   input  logic [NUM_CH*STEP_W-1:0]  step,
   input  logic                      wake_req,
   input  logic                      load_en,
   input  logic [$clog2(NUM_CH)-1:0] load_ch,
   input  logic [WIDTH-1:0]          load_val,
   output logic [NUM_CH*WIDTH-1:0]   value,
   output logic [NUM_CH*2-1:0]       indicator,
   output logic [1:0]                sleep_state,
   output logic                      asleep,
   output logic                      fell_asleep,
   output logic                      woke_up
);

   localparam int CH_W = $clog2(NUM_CH);
   localparam int DC_W = (DECAY_PERIOD > 2) ? $clog2(DECAY_PERIOD) : 1;
   localparam int SC_W = $clog2(SLEEP_DELAY + 1);

   typedef enum logic [1:0] {AWAKE = 2'd0, DROWSY = 2'd1, ASLEEP = 2'd2, WAKING = 2'd3} state_t;

   state_t            state, state_nxt;
   logic [SC_W-1:0]   drowsy_cnt, drowsy_nxt;
   logic [DC_W-1:0]   decay_cnt;
   logic              decay_hit;
   logic [WIDTH-1:0]  val     [NUM_CH];
   logic [WIDTH-1:0]  val_nxt [NUM_CH];
   logic [1:0]        ind0;
   logic              asleep_nxt, fell_nxt, woke_nxt;

   function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] v, input logic [STEP_W-1:0] s);
      logic [WIDTH:0] sum;
      sum = {1'b0, v} + (WIDTH+1)'(s);
      return sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
   endfunction

   function automatic logic [WIDTH-1:0] sat_sub(input logic [WIDTH-1:0] v, input logic [STEP_W-1:0] s);
      logic [WIDTH:0] diff;
      diff = {1'b0, v} - (WIDTH+1)'(s);
      return diff[WIDTH] ? '0 : diff[WIDTH-1:0];
   endfunction

   function automatic logic [WIDTH-1:0] toward(input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] b);
      if (v < b)      return v + WIDTH'(1);
      else if (v > b) return v - WIDTH'(1);
      else            return v;
   endfunction

   assign ind0      = val[0][WIDTH-1 -: 2];
   assign decay_hit = tick && (decay_cnt == DC_W'(DECAY_PERIOD - 1));

   // Channel update: load > sleep override > inc/dec > decay
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         val_nxt[c] = val[c];
         if (load_en && (load_ch == CH_W'(c))) begin
            val_nxt[c] = load_val;
         end else if (tick) begin
            if ((state == ASLEEP) && (c == 0)) begin
               val_nxt[c] = sat_add(val[c], STEP_W'(1));
            end else if ((state == ASLEEP) && (c == 1)) begin
               val_nxt[c] = sat_sub(val[c], STEP_W'(1));
            end else if (inc[c] && !dec[c]) begin
               val_nxt[c] = sat_add(val[c], step[c*STEP_W +: STEP_W]);
            end else if (dec[c] && !inc[c]) begin
               val_nxt[c] = sat_sub(val[c], step[c*STEP_W +: STEP_W]);
            end else if (!inc[c] && !dec[c] && decay_hit) begin
               val_nxt[c] = toward(val[c], BASELINE[c*WIDTH +: WIDTH]);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         decay_cnt <= '0;
         for (int c = 0; c < NUM_CH; c++) val[c] <= BASELINE[c*WIDTH +: WIDTH];
      end else begin
         if (tick) decay_cnt <= decay_hit ? '0 : decay_cnt + DC_W'(1);
         for (int c = 0; c < NUM_CH; c++) val[c] <= val_nxt[c];
      end
   end

   // FSM state register, including the registered status outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= AWAKE;
         drowsy_cnt  <= '0;
         asleep      <= 1'b0;
         fell_asleep <= 1'b0;
         woke_up     <= 1'b0;
      end else begin
         state       <= state_nxt;
         drowsy_cnt  <= drowsy_nxt;
         asleep      <= asleep_nxt;
         fell_asleep <= fell_nxt;
         woke_up     <= woke_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      drowsy_nxt = drowsy_cnt;
      case (state)
         AWAKE: begin
            if (tick && (ind0 == 2'd0)) begin
               state_nxt  = DROWSY;
               drowsy_nxt = '0;
            end
         end
         DROWSY: begin
            if (tick) begin
               if (ind0 != 2'd0) begin
                  state_nxt  = AWAKE;
                  drowsy_nxt = '0;
               end else if ((drowsy_cnt + SC_W'(1)) == SC_W'(SLEEP_DELAY)) begin
                  state_nxt  = ASLEEP;
                  drowsy_nxt = '0;
               end else begin
                  drowsy_nxt = drowsy_cnt + SC_W'(1);
               end
            end
         end
         // wake_req acts without tick but only once energy is in the upper half
         ASLEEP: begin
            if ((tick && (ind0 == 2'd3)) || (wake_req && ind0[1])) state_nxt = WAKING;
         end
         WAKING: state_nxt = AWAKE;
         default: state_nxt = AWAKE;
      endcase
   end

   always_comb begin
      asleep_nxt = (state_nxt == ASLEEP);
      fell_nxt   = (state == DROWSY) && (state_nxt == ASLEEP);
      woke_nxt   = (state == WAKING) && (state_nxt == AWAKE);
   end

   assign sleep_state = state;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_out
      assign value[g*WIDTH +: WIDTH] = val[g];
      assign indicator[g*2 +: 2]     = val[g][WIDTH-1 -: 2];
   end

endmodule

// File: tb/tb_mood_state_engine.sv
// Self-checking bench for mood_state_engine with default parameters: vector table
// plus hand-written decay and sleep sequences, checked through an expectation queue.
module tb_mood_state_engine;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b0;
   logic [2:0] inc = '0;
   logic [2:0] dec = '0;
   logic [8:0] step = '0;
   logic       wake_req = 1'b0;
   logic       load_en = 1'b0;
   logic [1:0] load_ch = '0;
   logic [6:0] load_val = '0;
   logic [20:0] value;
   logic [5:0]  indicator;
   logic [1:0]  sleep_state;
   logic        asleep, fell_asleep, woke_up;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      string      name;
      logic       rn, tk;
      logic [2:0] inc, dec;
      logic [8:0] step;
      logic       wk, ld;
      logic [1:0] ldch;
      logic [6:0] ldval;
      logic [6:0] e0, e1, e2;
      logic [1:0] es;
      logic       ea, ef, ew;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];

   mood_state_engine dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .inc(inc), .dec(dec), .step(step),
      .wake_req(wake_req), .load_en(load_en), .load_ch(load_ch), .load_val(load_val),
      .value(value), .indicator(indicator), .sleep_state(sleep_state),
      .asleep(asleep), .fell_asleep(fell_asleep), .woke_up(woke_up)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input string n, input logic rn, input logic tk,
                               input logic [2:0] i, input logic [2:0] d, input logic [8:0] s,
                               input logic wk, input logic ld, input logic [1:0] lc, input logic [6:0] lv,
                               input logic [6:0] e0, input logic [6:0] e1, input logic [6:0] e2,
                               input logic [1:0] es, input logic ea, input logic ef, input logic ew);
      vec_t v;
      v.name = n; v.rn = rn; v.tk = tk; v.inc = i; v.dec = d; v.step = s;
      v.wk = wk; v.ld = ld; v.ldch = lc; v.ldval = lv;
      v.e0 = e0; v.e1 = e1; v.e2 = e2; v.es = es; v.ea = ea; v.ef = ef; v.ew = ew;
      return v;
   endfunction

   task automatic check_one();
      vec_t e;
      logic [20:0] ev;
      logic [5:0]  ei;
      if (exp_q.size() == 0) begin
         n_chk++; n_fail++;
         $display("FAIL scoreboard: no expectation queued");
         return;
      end
      e  = exp_q.pop_front();
      ev = {e.e2, e.e1, e.e0};
      ei = {e.e2[6:5], e.e1[6:5], e.e0[6:5]};
      n_chk++;
      if (value !== ev || indicator !== ei || sleep_state !== e.es ||
          asleep !== e.ea || fell_asleep !== e.ef || woke_up !== e.ew) begin
         n_fail++;
         $display("FAIL %s: got ch=%0d/%0d/%0d ind=%b st=%0d a/f/w=%b%b%b, want ch=%0d/%0d/%0d ind=%b st=%0d a/f/w=%b%b%b",
                  e.name, value[6:0], value[13:7], value[20:14], indicator, sleep_state,
                  asleep, fell_asleep, woke_up, e.e0, e.e1, e.e2, ei, e.es, e.ea, e.ef, e.ew);
      end
   endtask

   task automatic apply(input vec_t v);
      @(negedge clk);
      rst_n = v.rn; tick = v.tk; inc = v.inc; dec = v.dec; step = v.step;
      wake_req = v.wk; load_en = v.ld; load_ch = v.ldch; load_val = v.ldval;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      check_one();
   endtask

   // Reset, load ch0=20 and ch1=10, then five ticks: DROWSY on the first, ASLEEP on the fifth
   task automatic go_sleep(input string tag);
      apply(mk({tag, "_rst"},   0, 0, 3'b000, 3'b000, 9'd0, 0, 0, 2'd0, 7'd0, 96, 0, 64, 2'd0, 0, 0, 0));
      apply(mk({tag, "_ld0"},   1, 0, 3'b000, 3'b000, 9'd0, 0, 1, 2'd0, 7'd20, 20, 0, 64, 2'd0, 0, 0, 0));
      apply(mk({tag, "_ld1"},   1, 0, 3'b000, 3'b000, 9'd0, 0, 1, 2'd1, 7'd10, 20, 10, 64, 2'd0, 0, 0, 0));
      for (int k = 1; k <= 4; k++)
         apply(mk({tag, "_drowsy"}, 1, 1, 3'b000, 3'b000, 9'd0, 0, 0, 2'd0, 7'd0, 20, 10, 64, 2'd1, 0, 0, 0));
      apply(mk({tag, "_fell"},  1, 1, 3'b000, 3'b000, 9'd0, 0, 0, 2'd0, 7'd0, 20, 10, 64, 2'd2, 1, 1, 0));
   endtask

   initial begin
      // name rn tk inc dec step wk ld ldch ldval e0 e1 e2 st a f w
      tbl.push_back(mk("reset",        0, 0, 3'b000, 3'b000, 9'd0,          0, 0, 2'd0, 7'd0,   96, 0, 64, 2'd0, 0, 0, 0));
      tbl.push_back(mk("load_ch0",     1, 0, 3'b000, 3'b000, 9'd0,          0, 1, 2'd0, 7'd125, 125, 0, 64, 2'd0, 0, 0, 0));
      tbl.push_back(mk("inc_sat_max",  1, 1, 3'b001, 3'b000, 9'b000_000_101, 0, 0, 2'd0, 7'd0,  127, 0, 64, 2'd0, 0, 0, 0));
      tbl.push_back(mk("dec_sat_zero", 1, 1, 3'b000, 3'b010, 9'b000_011_000, 0, 0, 2'd0, 7'd0,  127, 0, 64, 2'd0, 0, 0, 0));
      tbl.push_back(mk("inc_dec_both", 1, 1, 3'b100, 3'b100, 9'b100_000_000, 0, 0, 2'd0, 7'd0,  127, 0, 64, 2'd0, 0, 0, 0));
      tbl.push_back(mk("inc_no_tick",  1, 0, 3'b111, 3'b000, 9'h1FF,        0, 0, 2'd0, 7'd0,   127, 0, 64, 2'd0, 0, 0, 0));
      tbl.push_back(mk("dec_no_tick",  1, 0, 3'b000, 3'b111, 9'h1FF,        0, 0, 2'd0, 7'd0,   127, 0, 64, 2'd0, 0, 0, 0));
      tbl.push_back(mk("load_bad_ch",  1, 0, 3'b000, 3'b000, 9'd0,          0, 1, 2'd3, 7'd5,   127, 0, 64, 2'd0, 0, 0, 0));
      tbl.push_back(mk("load_wins",    1, 1, 3'b000, 3'b010, 9'h1FF,        0, 1, 2'd1, 7'd50,  127, 50, 64, 2'd0, 0, 0, 0));
      tbl.push_back(mk("inc_ch1",      1, 1, 3'b010, 3'b000, 9'b000_111_000, 0, 0, 2'd0, 7'd0,  127, 57, 64, 2'd0, 0, 0, 0));
      tbl.push_back(mk("dec_ch2",      1, 1, 3'b000, 3'b100, 9'b111_000_000, 0, 0, 2'd0, 7'd0,  127, 57, 57, 2'd0, 0, 0, 0));
      tbl.push_back(mk("inc_ch2",      1, 1, 3'b100, 3'b000, 9'b111_000_000, 0, 0, 2'd0, 7'd0,  127, 57, 64, 2'd0, 0, 0, 0));
      tbl.push_back(mk("load_ch1_2",   1, 0, 3'b000, 3'b000, 9'd0,          0, 1, 2'd1, 7'd2,   127, 2, 64, 2'd0, 0, 0, 0));
      tbl.push_back(mk("dec_clamp",    1, 1, 3'b000, 3'b010, 9'b000_101_000, 0, 0, 2'd0, 7'd0,  127, 0, 64, 2'd0, 0, 0, 0));
      tbl.push_back(mk("load_ch2_125", 1, 0, 3'b000, 3'b000, 9'd0,          0, 1, 2'd2, 7'd125, 127, 0, 125, 2'd0, 0, 0, 0));
      tbl.push_back(mk("inc_clamp",    1, 1, 3'b100, 3'b000, 9'b110_000_000, 0, 0, 2'd0, 7'd0,  127, 0, 127, 2'd0, 0, 0, 0));

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

      // Decay: ch2 from 70 steps down once per 16 ticks
      apply(mk("decay_rst", 0, 0, 3'b000, 3'b000, 9'd0, 0, 0, 2'd0, 7'd0, 96, 0, 64, 2'd0, 0, 0, 0));
      apply(mk("decay_ld",  1, 0, 3'b000, 3'b000, 9'd0, 0, 1, 2'd2, 7'd70, 96, 0, 70, 2'd0, 0, 0, 0));
      for (int k = 1; k <= 32; k++)
         apply(mk("decay_idle", 1, 1, 3'b000, 3'b000, 9'd0, 0, 0, 2'd0, 7'd0, 96, 0,
                  (k < 16) ? 7'd70 : ((k < 32) ? 7'd69 : 7'd68), 2'd0, 0, 0, 0));

      // Step-0 activity on ch2 suppresses its decay while ch1 still decays
      apply(mk("supp_rst", 0, 0, 3'b000, 3'b000, 9'd0, 0, 0, 2'd0, 7'd0, 96, 0, 64, 2'd0, 0, 0, 0));
      apply(mk("supp_ld2", 1, 0, 3'b000, 3'b000, 9'd0, 0, 1, 2'd2, 7'd70, 96, 0, 70, 2'd0, 0, 0, 0));
      apply(mk("supp_ld1", 1, 0, 3'b000, 3'b000, 9'd0, 0, 1, 2'd1, 7'd3,  96, 3, 70, 2'd0, 0, 0, 0));
      for (int k = 1; k <= 15; k++)
         apply(mk("supp_idle", 1, 1, 3'b000, 3'b000, 9'd0, 0, 0, 2'd0, 7'd0, 96, 3, 70, 2'd0, 0, 0, 0));
      apply(mk("supp_tick16", 1, 1, 3'b100, 3'b000, 9'd0, 0, 0, 2'd0, 7'd0, 96, 2, 70, 2'd0, 0, 0, 0));

      // Sleep entry, override ramp, ignored and accepted wake_req
      go_sleep("s1");
      apply(mk("s1_pulse_end", 1, 0, 3'b000, 3'b000, 9'd0, 0, 0, 2'd0, 7'd0, 20, 10, 64, 2'd2, 1, 0, 0));
      for (int k = 1; k <= 12; k++)
         apply(mk("s1_override", 1, 1, 3'b001, 3'b010, 9'h1FF, 0, 0, 2'd0, 7'd0,
                  7'(20 + k), (k < 10) ? 7'(10 - k) : 7'd0, 64, 2'd2, 1, 0, 0));
      apply(mk("s1_ld40",    1, 0, 3'b000, 3'b000, 9'd0, 0, 1, 2'd0, 7'd40, 40, 0, 64, 2'd2, 1, 0, 0));
      apply(mk("s1_wake_lo", 1, 0, 3'b000, 3'b000, 9'd0, 1, 0, 2'd0, 7'd0,  40, 0, 64, 2'd2, 1, 0, 0));
      apply(mk("s1_no_latch",1, 0, 3'b000, 3'b000, 9'd0, 0, 0, 2'd0, 7'd0,  40, 0, 64, 2'd2, 1, 0, 0));
      apply(mk("s1_ld64",    1, 0, 3'b000, 3'b000, 9'd0, 0, 1, 2'd0, 7'd64, 64, 0, 64, 2'd2, 1, 0, 0));
      apply(mk("s1_wake_hi", 1, 0, 3'b000, 3'b000, 9'd0, 1, 0, 2'd0, 7'd0,  64, 0, 64, 2'd3, 0, 0, 0));
      apply(mk("s1_awake",   1, 0, 3'b000, 3'b000, 9'd0, 0, 0, 2'd0, 7'd0,  64, 0, 64, 2'd0, 0, 0, 1));
      apply(mk("s1_woke_end",1, 0, 3'b000, 3'b000, 9'd0, 0, 0, 2'd0, 7'd0,  64, 0, 64, 2'd0, 0, 0, 0));

      // Wake through indicator 3 on a tick
      go_sleep("s2");
      apply(mk("s2_ld126", 1, 0, 3'b000, 3'b000, 9'd0, 0, 1, 2'd0, 7'd126, 126, 10, 64, 2'd2, 1, 0, 0));
      apply(mk("s2_q3",    1, 1, 3'b000, 3'b000, 9'd0, 0, 0, 2'd0, 7'd0,   127, 9, 64, 2'd3, 0, 0, 0));
      apply(mk("s2_awake", 1, 0, 3'b000, 3'b000, 9'd0, 0, 0, 2'd0, 7'd0,   127, 9, 64, 2'd0, 0, 0, 1));

      // Reset while asleep, with load and wake requests active
      go_sleep("s3");
      apply(mk("s3_rst_load", 0, 1, 3'b111, 3'b000, 9'h1FF, 1, 1, 2'd0, 7'd5, 96, 0, 64, 2'd0, 0, 0, 0));
      apply(mk("s3_after",    1, 0, 3'b000, 3'b000, 9'd0,   0, 0, 2'd0, 7'd0, 96, 0, 64, 2'd0, 0, 0, 0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
